// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
package mult_pkg;

  localparam int NIB_W = 4;
  localparam int OP_W  = 8;
  localparam int P_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Partial-product shift for each step: lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    step_shift = 4'd0;
      2'd1:    step_shift = 4'd4;
      2'd2:    step_shift = 4'd4;
      default: step_shift = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Operand/result handshake bundle between producer, multiplier and consumer.
interface mult8_seq_ctrl_if import mult_pkg::*; ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [P_W-1:0]    p;

  // Environment side: supplies operands, consumes the product.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );

endinterface

// File: rtl/mult8_seq_ctrl_array_mult.sv
// 4x4 unsigned combinational array multiplier (shifted AND rows summed).
module array_multiplier_4_bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  logic [7:0] row0, row1, row2, row3;

  // Form the four shifted partial-product rows and add them.
  always_comb begin
    row0 = {4'b0000, A & {4{B[0]}}};
    row1 = {3'b000,  A & {4{B[1]}}, 1'b0};
    row2 = {2'b00,   A & {4{B[2]}}, 2'b00};
    row3 = {1'b0,    A & {4{B[3]}}, 3'b000};
    P    = row0 + row1 + row2 + row3;
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 array, four steps,
// valid/ready on both sides, synchronous flush and optional zero bypass.
module mult8_seq_ctrl
  import mult_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mult8_seq_ctrl_if.slave   bus,
  input  logic              flush,
  output logic              busy
);

  state_t             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
  logic [P_W-1:0]     acc_q, acc_d, p_q, p_d;

  logic [NIB_W-1:0]   mul_a, mul_b;
  logic [2*NIB_W-1:0] pp;
  logic [P_W-1:0]     pp_sh, sum;

  array_multiplier_4_bits u_mul (
    .A(mul_a),
    .B(mul_b),
    .P(pp)
  );

  // Pick the nibble pair for this step and align its product into the sum.
  always_comb begin
    mul_a = step_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
    mul_b = step_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];
    pp_sh = P_W'(pp) << step_shift(step_q);
    sum   = acc_q + pp_sh;
  end

  // Next-state logic; flush overrides accept and completion.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    if (flush) begin
      state_d = IDLE;
      step_d  = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_d    = bus.a;
            b_d    = bus.b;
            acc_d  = '0;
            step_d = 2'd0;
            if (SKIP_ZERO && ((bus.a == '0) || (bus.b == '0))) begin
              p_d     = '0;
              state_d = DONE;
            end else begin
              state_d = MUL;
            end
          end
        end
        MUL: begin
          acc_d  = sum;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            p_d     = sum;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, operand, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;
  assign busy          = (state_q == MUL);

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed bench for mult8_seq_ctrl: one instance with zero bypass, one without.
module tb_mult8_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy0, busy1;

  int n_vec  = 0;
  int n_miss = 0;

  int          lat0, lat1, busy_cnt0, nrdy_cnt0;
  logic [15:0] p0, p1;
  logic [15:0] acc_tr [12];
  logic        seen_valid;

  mult8_seq_ctrl_if bus0 ();
  mult8_seq_ctrl_if bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.a         = a;
  assign bus0.b         = b;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.a         = a;
  assign bus1.b         = b;
  assign bus1.out_ready = out_ready;

  mult8_seq_ctrl #(.SKIP_ZERO(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .flush(flush), .busy(busy0)
  );

  mult8_seq_ctrl #(.SKIP_ZERO(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .flush(flush), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single cycle, then observe 11 cycles.
  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb);
    lat0 = -1; lat1 = -1; busy_cnt0 = 0; nrdy_cnt0 = 0;
    p0 = 16'hxxxx; p1 = 16'hxxxx;
    a = aa; b = bb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      acc_tr[k] = dut0.acc_q;
      if (bus0.out_valid && lat0 < 0) begin lat0 = k; p0 = bus0.p; end
      if (bus1.out_valid && lat1 < 0) begin lat1 = k; p1 = bus1.p; end
      if (busy0) busy_cnt0++;
      if (!bus0.in_ready) nrdy_cnt0++;
      if (k < 11) tick();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready",  32'(bus0.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_busy",      32'(busy0),          32'd0);
    check("rst_p",         32'(bus0.p),         32'h0);

    // 0x12 * 0x34
    run_op(8'h12, 8'h34);
    check("t1_latency",   32'(lat0),      32'd5);
    check("t1_busy_cnt",  32'(busy_cnt0), 32'd4);
    check("t1_nrdy_cnt",  32'(nrdy_cnt0), 32'd5);
    check("t1_p",         32'(p0),        32'h03A8);
    check("t1_latency_noskip", 32'(lat1), 32'd5);

    // 0xFF * 0xFF with per-step accumulator trace
    run_op(8'hFF, 8'hFF);
    check("t2_p",    32'(p0),        32'hFE01);
    check("t2_acc0", 32'(acc_tr[2]), 32'h00E1);
    check("t2_acc1", 32'(acc_tr[3]), 32'h0EF1);
    check("t2_acc2", 32'(acc_tr[4]), 32'h1D01);
    check("t2_acc3", 32'(acc_tr[5]), 32'hFE01);

    // Zero operand: bypass on dut0, full path on dut1
    run_op(8'h00, 8'hAB);
    check("t3_skip_latency",   32'(lat0),      32'd1);
    check("t3_skip_busy_cnt",  32'(busy_cnt0), 32'd0);
    check("t3_skip_p",         32'(p0),        32'h0000);
    check("t3_noskip_latency", 32'(lat1),      32'd5);
    check("t3_noskip_p",       32'(p1),        32'h0000);

    // Backpressure: hold result for 7 cycles
    out_ready = 1'b0;
    a = 8'h0F; b = 8'h10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 7; i++) begin
      check("bp_hold", {14'd0, bus0.out_valid, bus0.in_ready, bus0.p},
                       {14'd0, 1'b1, 1'b0, 16'h00F0});
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready",  32'(bus0.in_ready),  32'd1);
    check("bp_release_out_valid", 32'(bus0.out_valid), 32'd0);
    run_op(8'h02, 8'h03);
    check("bp_next_p",       32'(p0),   32'h0006);
    check("bp_next_latency", 32'(lat0), 32'd5);

    // Flush during step 2
    a = 8'h55; b = 8'hAA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("fl_step", 32'(dut0.step_q), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_in_ready",  32'(bus0.in_ready),  32'd1);
    check("fl_busy",      32'(busy0),          32'd0);
    check("fl_out_valid", 32'(bus0.out_valid), 32'd0);
    check("fl_p_kept",    32'(bus0.p),         32'h0006);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus0.out_valid || bus1.out_valid) seen_valid = 1'b1;
      tick();
    end
    check("fl_no_valid", 32'(seen_valid), 32'd0);
    run_op(8'h03, 8'h05);
    check("fl_next_p",   32'(p0), 32'h000F);
    check("fl_next_p_1", 32'(p1), 32'h000F);

    // Asynchronous reset between edges mid-MUL
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready",  32'(bus0.in_ready),  32'd1);
    check("arst_p",         32'(bus0.p),         32'h0);
    check("arst_busy",      32'(busy0),          32'd0);
    check("arst_out_valid", 32'(bus0.out_valid), 32'd0);
    #2 rst = 1'b0;
    tick();
    run_op(8'h07, 8'h09);
    check("arst_next_p",       32'(p0),   32'h003F);
    check("arst_next_latency", 32'(lat0), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
